// File: rtl/id_stage_fwd_if.sv
// Decode-stage bus: IF/ID handshake, EX forward, WB write port and the ID/EX register outputs.
// master = surrounding pipeline, slave = id_stage_fwd.
interface id_stage_fwd_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            flush_i;
   logic            if_valid_i;
   logic            if_ready_o;
   logic [31:0]     instr_i;
   logic            exfwd_valid_i;
   logic [AW-1:0]   exfwd_addr_i;
   logic [XLEN-1:0] exfwd_data_i;
   logic            wb_we_i;
   logic [AW-1:0]   wb_waddr_i;
   logic [XLEN-1:0] wb_wdata_i;
   logic            ex_valid_o;
   logic            ex_ready_i;
   logic [AW-1:0]   ex_rd_addr_o;
   logic            ex_we_o;
   logic [XLEN-1:0] ex_rs1_data_o;
   logic [XLEN-1:0] ex_rs2_data_o;
   logic [XLEN-1:0] ex_imm_o;
   logic            ex_use_imm_o;
   logic [3:0]      ex_alu_op_o;
   logic            ex_is_load_o;

   modport master (
      output flush_i, if_valid_i, instr_i, exfwd_valid_i, exfwd_addr_i, exfwd_data_i,
             wb_we_i, wb_waddr_i, wb_wdata_i, ex_ready_i,
      input  if_ready_o, ex_valid_o, ex_rd_addr_o, ex_we_o, ex_rs1_data_o, ex_rs2_data_o,
             ex_imm_o, ex_use_imm_o, ex_alu_op_o, ex_is_load_o
   );

   modport slave (
      input  flush_i, if_valid_i, instr_i, exfwd_valid_i, exfwd_addr_i, exfwd_data_i,
             wb_we_i, wb_waddr_i, wb_wdata_i, ex_ready_i,
      output if_ready_o, ex_valid_o, ex_rd_addr_o, ex_we_o, ex_rs1_data_o, ex_rs2_data_o,
             ex_imm_o, ex_use_imm_o, ex_alu_op_o, ex_is_load_o
   );
endinterface

// File: rtl/id_stage_fwd.sv
// RV32I ALU/load decode stage: register file, EX/WB operand bypass, load-use interlock
// and a valid/ready ID/EX pipeline register with flush.
module id_stage_fwd #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic           clk_i,
   input logic           rst_i,
   id_stage_fwd_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_op, is_opimm, is_load, use_rs1, use_rs2;
   logic [AW-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0] imm, rf_rs1, rf_rs2, rs1_data, rs2_data;
   logic [3:0]      alu_op;
   logic            rd_we, hazard, adv, issue;
   logic [XLEN-1:0] rf [NUM_REGS];

   logic            ex_valid_q, ex_we_q, ex_use_imm_q, ex_is_load_q;
   logic [AW-1:0]   ex_rd_q;
   logic [XLEN-1:0] ex_rs1_q, ex_rs2_q, ex_imm_q;
   logic [3:0]      ex_alu_op_q;

   function automatic logic [XLEN-1:0] pick(
      input logic [AW-1:0] a, input logic [XLEN-1:0] rfv,
      input logic fv, input logic [AW-1:0] fa, input logic [XLEN-1:0] fd,
      input logic wv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      if (ZERO_REG != 0 && a == '0)           return '0;
      else if (fv && fa == a)                 return fd;
      else if (BYPASS != 0 && wv && wa == a)  return wd;
      else                                    return rfv;
   endfunction

   assign opcode   = bus.instr_i[6:0];
   assign funct3   = bus.instr_i[14:12];
   assign rs1      = AW'(bus.instr_i[19:15]);
   assign rs2      = AW'(bus.instr_i[24:20]);
   assign rd       = AW'(bus.instr_i[11:7]);
   assign is_op    = (opcode == 7'b0110011);
   assign is_opimm = (opcode == 7'b0010011);
   assign is_load  = (opcode == 7'b0000011);
   assign use_rs1  = is_op | is_opimm | is_load;
   assign use_rs2  = is_op;
   assign rd_we    = use_rs1 & ~(ZERO_REG != 0 && rd == '0);
   assign imm      = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};

   // instr[30] only selects SUB/SRA for OP and SRAI for OP-IMM; elsewhere it is immediate data
   always_comb begin
      alu_op = 4'b0000;
      if (is_op)         alu_op = {bus.instr_i[30], funct3};
      else if (is_opimm) alu_op = {bus.instr_i[30] & (funct3 == 3'b101), funct3};
   end

   assign rf_rs1   = (32'(rs1) < NUM_REGS) ? rf[rs1] : '0;
   assign rf_rs2   = (32'(rs2) < NUM_REGS) ? rf[rs2] : '0;
   assign rs1_data = pick(rs1, rf_rs1, bus.exfwd_valid_i, bus.exfwd_addr_i, bus.exfwd_data_i,
                          bus.wb_we_i, bus.wb_waddr_i, bus.wb_wdata_i);
   assign rs2_data = pick(rs2, rf_rs2, bus.exfwd_valid_i, bus.exfwd_addr_i, bus.exfwd_data_i,
                          bus.wb_we_i, bus.wb_waddr_i, bus.wb_wdata_i);

   // Load result is not forwardable from EX; hold ID one cycle so it arrives via WB
   assign hazard = ex_valid_q & ex_is_load_q & ex_we_q &
                   ((use_rs1 & (rs1 == ex_rd_q)) | (use_rs2 & (rs2 == ex_rd_q)));
   assign adv    = bus.ex_ready_i | ~ex_valid_q;
   assign issue  = bus.if_valid_i & ~hazard;
   assign bus.if_ready_o = bus.flush_i | (adv & ~hazard);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (bus.wb_we_i && 32'(bus.wb_waddr_i) < NUM_REGS &&
                   !(ZERO_REG != 0 && bus.wb_waddr_i == '0)) begin
         rf[bus.wb_waddr_i] <= bus.wb_wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_valid_q   <= 1'b0;
         ex_rd_q      <= '0;
         ex_we_q      <= 1'b0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_imm_q     <= '0;
         ex_use_imm_q <= 1'b0;
         ex_alu_op_q  <= '0;
         ex_is_load_q <= 1'b0;
      end else if (bus.flush_i) begin
         ex_valid_q <= 1'b0;
      end else if (adv) begin
         ex_valid_q <= issue;
         if (issue) begin
            ex_rd_q      <= rd;
            ex_we_q      <= rd_we;
            ex_rs1_q     <= rs1_data;
            ex_rs2_q     <= rs2_data;
            ex_imm_q     <= imm;
            ex_use_imm_q <= is_opimm | is_load;
            ex_alu_op_q  <= alu_op;
            ex_is_load_q <= is_load;
         end
      end
   end

   assign bus.ex_valid_o    = ex_valid_q;
   assign bus.ex_rd_addr_o  = ex_rd_q;
   assign bus.ex_we_o       = ex_we_q;
   assign bus.ex_rs1_data_o = ex_rs1_q;
   assign bus.ex_rs2_data_o = ex_rs2_q;
   assign bus.ex_imm_o      = ex_imm_q;
   assign bus.ex_use_imm_o  = ex_use_imm_q;
   assign bus.ex_alu_op_o   = ex_alu_op_q;
   assign bus.ex_is_load_o  = ex_is_load_q;
endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: expectations queued on acceptance, compared on EX consumption.
// A BYPASS=0 twin runs in lockstep for the write-through comparison.
module tb_id_stage_fwd;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_stage_fwd_if #(.XLEN(32), .AW(5)) bus ();
   id_stage_fwd_if #(.XLEN(32), .AW(5)) bus_nb ();

   id_stage_fwd #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1))
      dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
   id_stage_fwd #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(0))
      dut_nb (.clk_i(clk), .rst_i(rst), .bus(bus_nb.slave));

   assign bus_nb.flush_i       = bus.flush_i;
   assign bus_nb.if_valid_i    = bus.if_valid_i;
   assign bus_nb.instr_i       = bus.instr_i;
   assign bus_nb.exfwd_valid_i = bus.exfwd_valid_i;
   assign bus_nb.exfwd_addr_i  = bus.exfwd_addr_i;
   assign bus_nb.exfwd_data_i  = bus.exfwd_data_i;
   assign bus_nb.wb_we_i       = bus.wb_we_i;
   assign bus_nb.wb_waddr_i    = bus.wb_waddr_i;
   assign bus_nb.wb_wdata_i    = bus.wb_wdata_i;
   assign bus_nb.ex_ready_i    = bus.ex_ready_i;

   typedef struct packed {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic        use_imm;
      logic [3:0]  op;
      logic        ld;
   } exp_t;

   logic [31:0] rf_m [32];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
      return {im, s1, f3, d, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d);
      return {f7, s2, s1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (bus.exfwd_valid_i && bus.exfwd_addr_i == r) return bus.exfwd_data_i;
      if (bus.wb_we_i && bus.wb_waddr_i == r) return bus.wb_wdata_i;
      return rf_m[r];
   endfunction

   function automatic exp_t model(input logic [31:0] ins);
      exp_t       e;
      logic [6:0] opc = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      logic       r   = (opc == 7'h33);
      logic       i   = (opc == 7'h13);
      logic       l   = (opc == 7'h03);
      e.rd      = ins[11:7];
      e.we      = (r | i | l) && (ins[11:7] != 5'd0);
      e.a       = opnd(ins[19:15]);
      e.b       = opnd(ins[24:20]);
      e.imm     = {{20{ins[31]}}, ins[31:20]};
      e.use_imm = i | l;
      e.ld      = l;
      if (r)                     e.op = {ins[30], f3};
      else if (i && f3 == 3'd5)  e.op = {ins[30], f3};
      else if (i)                e.op = {1'b0, f3};
      else                       e.op = 4'd0;
      return e;
   endfunction

   function automatic exp_t actual();
      return {bus.ex_rd_addr_o, bus.ex_we_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o,
              bus.ex_imm_o, bus.ex_use_imm_o, bus.ex_alu_op_o, bus.ex_is_load_o};
   endfunction

   task automatic idle();
      bus.flush_i = 1'b0; bus.if_valid_i = 1'b0; bus.instr_i = '0;
      bus.exfwd_valid_i = 1'b0; bus.exfwd_addr_i = '0; bus.exfwd_data_i = '0;
      bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
      bus.ex_ready_i = 1'b1;
   endtask

   // One clock: sample handshakes mid-cycle, queue/pop the scoreboard, track WB writes.
   task automatic step(output bit cons, output exp_t act, output exp_t exp, output bit acc);
      @(negedge clk);
      acc  = bus.if_valid_i && bus.if_ready_o && !bus.flush_i;
      cons = bus.ex_valid_o && bus.ex_ready_i && !bus.flush_i;
      act  = actual();
      exp  = 'x;
      if ((cons || (bus.flush_i && bus.ex_valid_o)) && sb.size() > 0) exp = sb.pop_front();
      if (acc) sb.push_back(model(bus.instr_i));
      @(posedge clk);
      if (bus.wb_we_i && bus.wb_waddr_i != 5'd0) rf_m[bus.wb_waddr_i] = bus.wb_wdata_i;
      #1;
   endtask

   task automatic test_reset();
      bit c, k; exp_t a, e;
      rst = 1'b1; idle();
      foreach (rf_m[i]) rf_m[i] = '0;
      #1;
      checks++; if (bus.ex_valid_o !== 1'b0 || actual() !== '0) begin errors++;
         $display("FAIL reset_outputs: got valid=%b %h expected 0", bus.ex_valid_o, actual()); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.if_ready_o !== 1'b1) begin errors++;
         $display("FAIL reset_ready: got %b expected 1", bus.if_ready_o); end
      bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd1; bus.wb_wdata_i = 32'h55;
      bus.if_valid_i = 1'b1; bus.instr_i = enc_i(12'h007, 5'd0, 3'd0, 5'd3, 7'h13);
      step(c, a, e, k);
      idle();
      checks++; if (bus.ex_valid_o !== 1'b1) begin errors++;
         $display("FAIL reset_prefill: got valid=%b expected 1", bus.ex_valid_o); end
      #2 rst = 1'b1; #1;
      checks++; if (bus.ex_valid_o !== 1'b0 || actual() !== '0) begin errors++;
         $display("FAIL reset_async: got valid=%b %h expected 0", bus.ex_valid_o, actual()); end
      sb.delete();
      foreach (rf_m[i]) rf_m[i] = '0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      bus.if_valid_i = 1'b1; bus.instr_i = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd6);
      step(c, a, e, k);
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL reset_regread: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL reset_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_forward();
      bit c, k; exp_t a, e;
      idle();
      bus.if_valid_i = 1'b1; bus.instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
      step(c, a, e, k);
      bus.instr_i = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
      bus.exfwd_valid_i = 1'b1; bus.exfwd_addr_i = 5'd1; bus.exfwd_data_i = 32'd5;
      step(c, a, e, k);
      if (c) begin checks++; if (a !== e) begin errors++;
         $display("FAIL fwd_addi: got %h expected %h", a, e); end end
      checks++; if (bus.ex_rs1_data_o !== 32'd5 || bus.ex_rs2_data_o !== 32'd5 || bus.ex_alu_op_o !== 4'b0000) begin
         errors++; $display("FAIL fwd_add: got %h %h op=%h expected 5 5 op=0",
                            bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_alu_op_o); end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL fwd_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL fwd_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_bypass();
      bit c, k; exp_t a, e;
      idle();
      bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd3; bus.wb_wdata_i = 32'hDEAD_BEEF;
      bus.if_valid_i = 1'b1; bus.instr_i = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd9);
      step(c, a, e, k);
      checks++; if (bus.ex_rs1_data_o !== 32'hDEAD_BEEF || bus_nb.ex_rs1_data_o !== 32'd0) begin errors++;
         $display("FAIL bypass_same_cycle: got %h/%h expected deadbeef/00000000",
                  bus.ex_rs1_data_o, bus_nb.ex_rs1_data_o); end
      bus.wb_we_i = 1'b1; bus.wb_wdata_i = 32'h2222;
      bus.exfwd_valid_i = 1'b1; bus.exfwd_addr_i = 5'd3; bus.exfwd_data_i = 32'h1111;
      bus.instr_i = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd9);
      step(c, a, e, k);
      if (c) begin checks++; if (a !== e) begin errors++;
         $display("FAIL bypass_q: got %h expected %h", a, e); end end
      checks++; if (bus_nb.ex_rs1_data_o !== 32'h1111) begin errors++;
         $display("FAIL bypass_fwd_prio: got %h expected 00001111", bus_nb.ex_rs1_data_o); end
      idle();
      bus.if_valid_i = 1'b1; bus.instr_i = enc_r(7'h00, 5'd3, 5'd0, 3'd0, 5'd9);
      step(c, a, e, k);
      if (c) begin checks++; if (a !== e) begin errors++;
         $display("FAIL bypass_q: got %h expected %h", a, e); end end
      checks++; if (bus_nb.ex_rs2_data_o !== 32'h2222) begin errors++;
         $display("FAIL bypass_rf_written: got %h expected 00002222", bus_nb.ex_rs2_data_o); end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL bypass_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL bypass_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      bit c, k; exp_t a, e;
      logic [31:0] prog [10];
      idle();
      for (int r = 1; r <= 4; r++) begin
         bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'(r); bus.wb_wdata_i = 32'h11 * r;
         step(c, a, e, k);
      end
      idle();
      prog = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7),
               enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 5'd8, 7'h13),
               enc_i({7'h00, 5'd3}, 5'd1, 3'd5, 5'd8, 7'h13),
               enc_i(12'h400, 5'd1, 3'd0, 5'd9, 7'h13),
               enc_i(12'hFFF, 5'd0, 3'd0, 5'd10, 7'h13),
               enc_i(12'hFFC, 5'd2, 3'd2, 5'd12, 7'h03),
               enc_r(7'h00, 5'd4, 5'd3, 3'd6, 5'd13),
               {20'hABCDE, 5'd5, 7'h37},
               enc_i(12'h001, 5'd1, 3'd0, 5'd0, 7'h13),
               enc_r(7'h20, 5'd3, 5'd4, 3'd5, 5'd6)};
      for (int i = 0; i < 10; i++) begin
         bus.if_valid_i = 1'b1; bus.instr_i = prog[i];
         step(c, a, e, k);
         checks++; if (k !== 1'b1) begin errors++;
            $display("FAIL b2b_accept[%0d]: got %b expected 1", i, k); end
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL b2b_q[%0d]: got %h expected %h", i, a, e); end end
      end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL b2b_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_load_use();
      bit c, k; exp_t a, e;
      idle();
      bus.if_valid_i = 1'b1; bus.instr_i = enc_i(12'h000, 5'd0, 3'd2, 5'd4, 7'h03);
      step(c, a, e, k);
      bus.instr_i = enc_r(7'h00, 5'd0, 5'd4, 3'd0, 5'd5);
      step(c, a, e, k);
      checks++; if (k !== 1'b0) begin errors++;
         $display("FAIL loaduse_stall: got ready=%b expected 0", k); end
      if (c) begin checks++; if (a !== e) begin errors++;
         $display("FAIL loaduse_lw: got %h expected %h", a, e); end end
      checks++; if (bus.ex_valid_o !== 1'b0) begin errors++;
         $display("FAIL loaduse_bubble: got valid=%b expected 0", bus.ex_valid_o); end
      bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd4; bus.wb_wdata_i = 32'd7;
      step(c, a, e, k);
      checks++; if (k !== 1'b1 || bus.ex_rs1_data_o !== 32'd7) begin errors++;
         $display("FAIL loaduse_resume: got ready=%b rs1=%h expected 1 00000007", k, bus.ex_rs1_data_o); end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL loaduse_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL loaduse_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      bit c, k; exp_t a, e, snap;
      idle();
      for (int i = 0; i < 3; i++) begin
         bus.if_valid_i = 1'b1; bus.instr_i = enc_i(12'(100 + i), 5'd2, 3'd4, 5'(20 + i), 7'h13);
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL bp_q: got %h expected %h", a, e); end end
      end
      bus.ex_ready_i = 1'b0; bus.instr_i = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd23);
      snap = actual();
      for (int i = 0; i < 3; i++) begin
         step(c, a, e, k);
         checks++; if (k !== 1'b0 || bus.ex_valid_o !== 1'b1 || actual() !== snap) begin errors++;
            $display("FAIL bp_hold[%0d]: got ready=%b valid=%b %h expected 0 1 %h",
                     i, k, bus.ex_valid_o, actual(), snap); end
      end
      bus.ex_ready_i = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL bp_q: got %h expected %h", a, e); end end
         if (k) break;
      end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL bp_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL bp_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_flush();
      bit c, k; exp_t a, e;
      idle();
      bus.ex_ready_i = 1'b0;
      bus.if_valid_i = 1'b1; bus.instr_i = enc_i(12'h033, 5'd1, 3'd0, 5'd15, 7'h13);
      step(c, a, e, k);
      bus.instr_i = enc_i(12'h044, 5'd1, 3'd0, 5'd16, 7'h13);
      bus.flush_i = 1'b1;
      bus.wb_we_i = 1'b1; bus.wb_waddr_i = 5'd0; bus.wb_wdata_i = 32'h1234;
      #1;
      checks++; if (bus.if_ready_o !== 1'b1) begin errors++;
         $display("FAIL flush_ready: got %b expected 1", bus.if_ready_o); end
      step(c, a, e, k);
      checks++; if (bus.ex_valid_o !== 1'b0) begin errors++;
         $display("FAIL flush_kill: got valid=%b expected 0", bus.ex_valid_o); end
      idle();
      bus.exfwd_valid_i = 1'b1; bus.exfwd_addr_i = 5'd0; bus.exfwd_data_i = 32'hFFFF;
      bus.if_valid_i = 1'b1; bus.instr_i = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd11);
      step(c, a, e, k);
      checks++; if (bus.ex_rs1_data_o !== 32'd0 || bus.ex_rs2_data_o !== 32'd0) begin errors++;
         $display("FAIL flush_x0: got %h %h expected 0 0", bus.ex_rs1_data_o, bus.ex_rs2_data_o); end
      idle();
      for (int n = 0; n < 6 && sb.size() > 0; n++) begin
         step(c, a, e, k);
         if (c) begin checks++; if (a !== e) begin errors++;
            $display("FAIL flush_q: got %h expected %h", a, e); end end
      end
      checks++; if (sb.size() != 0) begin errors++;
         $display("FAIL flush_drain: got %0d pending expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_bypass();
      test_back_to_back();
      test_load_use();
      test_backpressure();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
